// File: rtl/coffee_pkg.sv
// rtl/coffee_pkg.sv - shared status codes, timer states and code classification
//
// Purpose: common typedefs for Top, FSM2 and pour_timer so the status
// encoding lives in exactly one place.
// Ports: none (package).
package coffee_pkg;

  // FSM2 status code as presented on TH_M; 3'b111 is illegal and unnamed.
  typedef enum logic [2:0] {
    STANDBY       = 3'b000,
    WORKING       = 3'b001,
    POURINGCOFFEE = 3'b010,
    POURINGMILK   = 3'b011,
    NEEDMILK      = 3'b100,
    DONE          = 3'b101,
    ENJOY         = 3'b110
  } status_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    EXPIRED = 2'd2
  } timer_state_e;

  // Phases that have a programmed duration; STANDBY, NEEDMILK and the
  // illegal code are untimed.
  function automatic logic is_timed(input logic [2:0] code);
    case (code)
      WORKING, POURINGCOFFEE, POURINGMILK, DONE, ENJOY: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_down_counter.sv
// rtl/load_down_counter.sv - loadable down-counter with zero flag
//
// Purpose: holds the cycles-left count for the pour timer.
// Ports:
//   clk, reset  - clock, synchronous active-high reset (clears to 0)
//   load        - load load_val this cycle (wins over en)
//   load_val    - value to load
//   en          - decrement by one; saturates at 0
//   value       - current count
//   zero        - value == 0
module load_down_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (en && (value != '0)) begin
      value <= value - CNT_W'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/pour_timer.sv
// rtl/pour_timer.sv - per-phase duration timer feeding FSM2's T input
//
// Purpose: detects a change of the FSM2 status code, loads that phase's
// duration and issues a one-cycle registered T pulse when it elapses.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   TH_M       - FSM2 status code
//   hold       - freeze the count while high
//   T          - registered one-cycle phase-elapsed pulse
//   busy       - a timed phase is counting
//   remaining  - cycles left until T; 0 when not counting
module pour_timer
  import coffee_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int DUR_WORKING = 50,
  parameter int DUR_COFFEE  = 200,
  parameter int DUR_MILK    = 120,
  parameter int DUR_DONE    = 20,
  parameter int DUR_ENJOY   = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       TH_M,
  input  logic             hold,
  output logic             T,
  output logic             busy,
  output logic [CNT_W-1:0] remaining
);

  localparam int MAX_DUR = (2 ** CNT_W) - 1;

  if ((DUR_WORKING > MAX_DUR) || (DUR_COFFEE > MAX_DUR) || (DUR_MILK > MAX_DUR) ||
      (DUR_DONE > MAX_DUR) || (DUR_ENJOY > MAX_DUR)) begin : g_dur_range
    $error("pour_timer: a DUR_* parameter exceeds the CNT_W counter range");
  end

  // A zero duration would mean T in the same cycle as the change, which
  // a registered T cannot do, so the shortest phase is one cycle.
  localparam logic [CNT_W-1:0] D_WORKING = CNT_W'((DUR_WORKING == 0) ? 1 : DUR_WORKING);
  localparam logic [CNT_W-1:0] D_COFFEE  = CNT_W'((DUR_COFFEE  == 0) ? 1 : DUR_COFFEE);
  localparam logic [CNT_W-1:0] D_MILK    = CNT_W'((DUR_MILK    == 0) ? 1 : DUR_MILK);
  localparam logic [CNT_W-1:0] D_DONE    = CNT_W'((DUR_DONE    == 0) ? 1 : DUR_DONE);
  localparam logic [CNT_W-1:0] D_ENJOY   = CNT_W'((DUR_ENJOY   == 0) ? 1 : DUR_ENJOY);

  timer_state_e     state, next_state;
  logic [2:0]       th_prev;
  logic             change;
  logic             timed;
  logic [CNT_W-1:0] dur;
  logic             enter_expired;
  logic             cnt_load;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_zero;
  logic             last;

  assign change = (TH_M != th_prev);
  assign timed  = is_timed(TH_M);

  always_comb begin
    dur = D_WORKING;
    case (TH_M)
      WORKING:       dur = D_WORKING;
      POURINGCOFFEE: dur = D_COFFEE;
      POURINGMILK:   dur = D_MILK;
      DONE:          dur = D_DONE;
      ENJOY:         dur = D_ENJOY;
      default:       dur = D_WORKING;
    endcase
  end

  // The change cycle itself is cycle 0 of the phase, so the counter starts
  // at dur-1 in cycle 1 and the value always equals cycles left until T.
  assign cnt_load = change && timed;
  assign cnt_en   = (state == COUNT) && !hold && !change;
  assign last     = (cnt_en && (cnt_value == CNT_W'(1))) || ((state == COUNT) && cnt_zero);

  load_down_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (dur - CNT_W'(1)),
    .en       (cnt_en),
    .value    (cnt_value),
    .zero     (cnt_zero)
  );

  // State register; T and th_prev are registered alongside so T has no
  // combinational path from TH_M or hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      th_prev <= 3'b000;
      T       <= 1'b0;
    end else begin
      state   <= next_state;
      th_prev <= TH_M;
      T       <= enter_expired;
    end
  end

  // A status change always wins: it abandons whatever phase was running,
  // including one that would have expired this same cycle.
  always_comb begin
    next_state    = state;
    enter_expired = 1'b0;
    if (change) begin
      if (!timed) begin
        next_state = IDLE;
      end else if (dur == CNT_W'(1)) begin
        next_state    = EXPIRED;
        enter_expired = 1'b1;
      end else begin
        next_state = COUNT;
      end
    end else if (last) begin
      next_state    = EXPIRED;
      enter_expired = 1'b1;
    end
  end

  always_comb begin
    busy      = (state == COUNT);
    remaining = (state == COUNT) ? cnt_value : '0;
  end

endmodule
